instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Instruction-fetch front end for the MIPS core; the producer side of the main controller's interface.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents op/funct and the full instruction to the controller and datapath.
- Consumes the controller's pcsrc and jump decisions to form the next PC (PC+4, branch target or jump target).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch byte address; always equals pc, [1:0]=0
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr  out  32  registered current instruction
- op  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- instr_valid  out  1  instr holds a valid instruction awaiting retire
- advance  in  1  datapath retires current instruction this cycle
- pcsrc  in  1  take branch (branch & zero), sampled with advance
- jump  in  1  take jump, sampled with advance
- signimm  in  32  sign-extended immediate of current instruction
- pc  out  32  PC of current/being-fetched instruction
- pcplus4  out  32  pc + 4, combinational
- retired  out  CNT_W  count of retired instructions

Behaviour:
- FSM states:
  - S_IDLE: reset state. Next cycle goes to S_REQ unconditionally.
  - S_REQ: imem_req=1, imem_addr=pc, held stable until ack.
    - imem_ack=1: instr<=imem_rdata; go to S_EXEC.
    - Ack may arrive in the first S_REQ cycle, giving a minimum of 1 wait cycle.
  - S_EXEC: instr_valid=1, imem_req=0.
    - advance=1: pc<=next_pc, retired<=retired+1; go to S_REQ.
- next_pc, evaluated only when advance=1 in S_EXEC, by priority:
  - jump=1: {pcplus4[31:28], instr[25:0], 2'b00}.
  - else pcsrc=1: pcplus4 + (signimm<<2).
  - else: pcplus4.
  - jump wins if jump and pcsrc are both asserted.
- Latency: ack in cycle N gives instr/op/funct valid and instr_valid=1 in cycle N+1. Advance in cycle M gives imem_req=1 with the new address in cycle M+1.
- Ignored inputs:
  - imem_ack outside S_REQ: no state change.
  - advance, pcsrc, jump outside S_EXEC: no effect.
- Arithmetic: all PC arithmetic is mod 2^32. pc=32'hFFFF_FFFC with no branch/jump gives next pc 32'h0000_0000. next_pc[1:0] is forced to 00.
- retired wraps to 0 after all-ones, with no saturation.
- Registered outputs: imem_req, instr_valid, instr, pc, retired. imem_req and instr_valid derive from state only.
- Reset values: state=S_IDLE, pc=RESET_PC, instr=32'h0, instr_valid=0, imem_req=0, retired=0. Hence op=0, funct=0, pcplus4=RESET_PC+4, imem_addr=RESET_PC.
- Reset mid-fetch (S_REQ, ack pending): immediately returns all state to reset values and drops imem_req asynchronously. A later stray ack is ignored because the FSM is in S_IDLE.
- Reset in S_EXEC: instr_valid drops asynchronously; the pending instruction is discarded and not counted.

Test Plan:
- Reset, memory acks on first request cycle with 32'h2008_0005 -> imem_req=1 at addr 0 in cycle 2 after reset release; instr_valid=1 in cycle 3 with op=6'h08, funct=6'h05; retired=0.
- Sequential flow with 3-cycle ack latency, advance with pcsrc=0, jump=0 over three instructions -> imem_addr 0x0, 0x4, 0x8; addr stable while req high; retired=3.
- Branch: pc=0x10, signimm=32'hFFFF_FFFE, pcsrc=1 on advance -> next imem_addr=0x0C. Same with signimm=3 -> 0x20.
- Jump: pc=0x4000_0010, instr[25:0]=26'h000_0040, jump=1 and pcsrc=1 simultaneously -> next imem_addr=0x4000_0100 (jump priority).
- Boundary and ignored events: RESET_PC=32'hFFFF_FFFC, advance with no branch -> imem_addr=0x0. advance pulsed during S_REQ and stray ack during S_EXEC -> no pc, instr or retired change.
- Reset asserted while imem_req=1 and again while instr_valid=1 -> outputs return to reset values in the same cycle without a clock edge; fetch restarts at RESET_PC; retired=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - MIPS instruction fetch front end: PC, imem handshake, next-PC selection
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic [5:0]       funct,
    output logic             instr_valid,
    input  logic             advance,
    input  logic             pcsrc,
    input  logic             jump,
    input  logic [31:0]      signimm,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC
    } state_t;

    state_t      state;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc_raw;
    logic [31:0] next_pc;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign imem_addr = pc;
    assign op        = instr[31:26];
    assign funct     = instr[5:0];
    assign pcplus4   = pc + 32'd4;

    // Next PC: jump beats branch, branch beats sequential; word alignment is enforced on the result
    always_comb begin
        jump_target   = {pcplus4[31:28], instr[25:0], 2'b00};
        branch_target = pcplus4 + (signimm << 2);
        if (jump) begin
            next_pc_raw = jump_target;
        end else if (pcsrc) begin
            next_pc_raw = branch_target;
        end else begin
            next_pc_raw = pcplus4;
        end
        next_pc = next_pc_raw & ~32'h0000_0003;
    end

    // Fetch FSM: request until acked, hold the instruction until the datapath retires it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retired     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        state       <= S_EXEC;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (advance) begin
                        pc          <= next_pc;
                        retired     <= retired + CNT_ONE;
                        state       <= S_REQ;
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        rst_hi;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        advance;
    logic        pcsrc;
    logic        jump;
    logic [31:0] signimm;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] retired;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic [31:0] hi_instr;
    logic [5:0]  hi_op;
    logic [5:0]  hi_funct;
    logic        hi_valid;
    logic [31:0] hi_pc;
    logic [31:0] hi_pcplus4;
    logic [31:0] hi_retired;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
        .advance(advance), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .pc(pc), .pcplus4(pcplus4), .retired(retired)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) u_dut_hi (
        .clk(clk), .reset(rst_hi),
        .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(hi_instr), .op(hi_op), .funct(hi_funct), .instr_valid(hi_valid),
        .advance(advance), .pcsrc(pcsrc), .jump(jump), .signimm(signimm),
        .pc(hi_pc), .pcplus4(hi_pcplus4), .retired(hi_retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a fetch is outstanding, an instruction is held, or the unit is just out of reset
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_instr   = 32'h0;
    logic        m_valid   = 1'b0;
    logic        m_req     = 1'b0;
    logic [31:0] m_retired = 32'h0;

    always @(posedge clk or posedge reset) begin
        logic [31:0] seq;
        logic [31:0] tgt;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_req = 1'b0; m_retired = 32'h0;
        end else if (m_valid) begin
            if (advance) begin
                seq = m_pc + 32'd4;
                if (jump)       tgt = (seq & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
                else if (pcsrc) tgt = seq + signimm * 4;
                else            tgt = seq;
                m_pc = tgt;
                m_retired = m_retired + 1;
                m_valid = 1'b0;
                m_req = 1'b1;
            end
        end else if (m_req) begin
            if (imem_ack) begin
                m_instr = imem_rdata;
                m_req = 1'b0;
                m_valid = 1'b1;
            end
        end else begin
            m_req = 1'b1;
        end
    end

    // Compare every output against the model once per cycle, away from the active edge
    always @(negedge clk) begin
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("pcplus4", pcplus4, m_pc + 32'd4);
        chk("instr", instr, m_instr);
        chk("op", {26'b0, op}, m_instr >> 26);
        chk("funct", {26'b0, funct}, m_instr % 64);
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        chk("retired", retired, m_retired);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_fetch(input int lat, input logic [31:0] word);
        int n = 0;
        while (!imem_req && n < 50) begin
            step();
            n++;
        end
        if (!imem_req) chk("timeout_req", 32'd0, 32'd1);
        repeat (lat - 1) step();
        imem_ack = 1'b1;
        imem_rdata = word;
        step();
        imem_ack = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_advance(input logic ps, input logic j, input logic [31:0] si);
        int n = 0;
        while (!instr_valid && n < 50) begin
            step();
            n++;
        end
        if (!instr_valid) chk("timeout_valid", 32'd0, 32'd1);
        advance = 1'b1;
        pcsrc = ps;
        jump = j;
        signimm = si;
        step();
        advance = 1'b0;
        pcsrc = 1'b0;
        jump = 1'b0;
        signimm = 32'h0;
    endtask

    initial begin
        int n;
        reset = 1'b0; rst_hi = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        advance = 1'b0; pcsrc = 1'b0; jump = 1'b0; signimm = 32'h0;
        #1;
        reset = 1'b1; rst_hi = 1'b1;
        step();
        step();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_pcplus4", pcplus4, 32'h4);
        chk("rst_instr", instr, 32'h0);
        reset = 1'b0;
        step();
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        do_fetch(1, 32'h2008_0005);
        chk("first_valid", {31'b0, instr_valid}, 32'd1);
        chk("first_op", {26'b0, op}, 32'h08);
        chk("first_funct", {26'b0, funct}, 32'h05);
        chk("first_retired", retired, 32'd0);

        do_advance(1'b0, 1'b0, 32'h0);
        chk("seq_addr1", imem_addr, 32'h4);
        do_fetch(3, 32'h0000_0020);
        do_advance(1'b0, 1'b0, 32'h0);
        chk("seq_addr2", imem_addr, 32'h8);
        do_fetch(3, 32'h0000_0021);
        do_advance(1'b0, 1'b0, 32'h0);
        chk("seq_retired", retired, 32'd3);
        chk("seq_addr3", imem_addr, 32'hC);

        do_fetch(2, 32'h0000_0022);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        chk("stray_ack_instr", instr, 32'h0000_0022);
        chk("stray_ack_valid", {31'b0, instr_valid}, 32'd1);
        do_advance(1'b0, 1'b0, 32'h0);
        advance = 1'b1; jump = 1'b1; pcsrc = 1'b1; signimm = 32'h10;
        step();
        advance = 1'b0; jump = 1'b0; pcsrc = 1'b0; signimm = 32'h0;
        chk("stray_adv_pc", pc, 32'h10);
        chk("stray_adv_retired", retired, 32'd4);
        chk("stray_adv_req", {31'b0, imem_req}, 32'd1);

        do_fetch(1, 32'h1000_FFFE);
        do_advance(1'b1, 1'b0, 32'hFFFF_FFFE);
        chk("branch_back", imem_addr, 32'hC);
        do_fetch(1, 32'h0000_0020);
        do_advance(1'b0, 1'b0, 32'h0);
        do_fetch(1, 32'h1000_0003);
        do_advance(1'b1, 1'b0, 32'h3);
        chk("branch_fwd", imem_addr, 32'h20);
        do_fetch(1, 32'h1000_0000);
        do_advance(1'b1, 1'b0, 32'h0FFF_FFFB);
        chk("branch_far", imem_addr, 32'h4000_0010);
        do_fetch(1, 32'h0800_0040);
        do_advance(1'b1, 1'b1, 32'h5);
        chk("jump_prio", imem_addr, 32'h4000_0100);

        #1 reset = 1'b1;
        #1;
        chk("arst_req_req", {31'b0, imem_req}, 32'd0);
        chk("arst_req_addr", imem_addr, 32'h0);
        chk("arst_req_retired", retired, 32'd0);
        step();
        reset = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        step();
        imem_ack = 1'b0;
        chk("stray_after_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("stray_after_rst_req", {31'b0, imem_req}, 32'd1);
        do_fetch(1, 32'h2008_0005);
        #1 reset = 1'b1;
        #1;
        chk("arst_exec_valid", {31'b0, instr_valid}, 32'd0);
        chk("arst_exec_instr", instr, 32'h0);
        step();
        reset = 1'b0;
        do_fetch(1, 32'h0000_0020);
        do_advance(1'b0, 1'b0, 32'h0);
        chk("restart_addr", imem_addr, 32'h4);
        chk("restart_retired", retired, 32'd1);

        reset = 1'b1;
        step();
        rst_hi = 1'b0;
        n = 0;
        while (!hi_req && n < 20) begin
            step();
            n++;
        end
        chk("hi_req", {31'b0, hi_req}, 32'd1);
        chk("hi_addr", hi_addr, 32'hFFFF_FFFC);
        chk("hi_pcplus4", hi_pcplus4, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0;
        step();
        imem_ack = 1'b0;
        chk("hi_valid", {31'b0, hi_valid}, 32'd1);
        advance = 1'b1;
        step();
        advance = 1'b0;
        chk("hi_wrap_addr", hi_addr, 32'h0);
        chk("hi_retired", hi_retired, 32'd1);
        chk("hi_wrap_pcplus4", hi_pcplus4, 32'h4);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
